// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready on the operand side and on the result side.
interface alu_seq_if #(parameter int W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     S;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] ans;
    logic           zero;
    logic           ovf;
    logic           err;

    modport master (
        output in_valid, S, A, B, out_ready,
        input  in_ready, out_valid, ans, zero, ovf, err
    );

    modport slave (
        input  in_valid, S, A, B, out_ready,
        output in_ready, out_valid, ans, zero, ovf, err
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and flags.
// Optional shift-add multiplier for opcode 6 is compiled in when ALU_MUL_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// EXEC  | single-cycle opcode, result written on exit
// MUL   | shift-add iteration, one bit of B per cycle
// DONE  | result valid, waiting for out_ready
module alu_seq #(
    parameter int W = 8,
    localparam int SW = $clog2(W)
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam int CW = (SW < 1) ? 1 : SW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
`ifdef ALU_MUL_EN
        MUL  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [2:0]     s_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    logic [W:0]     sum;
    logic [W:0]     dif;
    logic [2*W-1:0] shl;
    logic [2*W-1:0] r_ans;
    logic           r_ovf;
    logic           r_err;

`ifdef ALU_MUL_EN
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [CW-1:0]  mcnt;
    logic [2*W-1:0] mul_sum;

    assign mul_sum = acc + (b_q[0] ? mcand : '0);
`endif

    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        dif   = {1'b0, a_q} - {1'b0, b_q};
        shl   = {{W{1'b0}}, a_q} << b_q[SW-1:0];
        r_ans = '0;
        r_ovf = 1'b0;
        r_err = 1'b0;
        case (s_q)
            3'd0: begin
                r_ans = {{(W-1){1'b0}}, sum};
                r_ovf = sum[W];
            end
            3'd1: begin
                r_ans = {{(W-1){1'b0}}, dif};
                r_ovf = (a_q < b_q);
            end
            3'd2:    r_ans = {{W{1'b0}}, a_q & b_q};
            3'd3:    r_ans = {{W{1'b0}}, a_q | b_q};
            3'd4:    r_ans = {{W{1'b0}}, a_q ^ b_q};
            3'd5:    r_ans = shl;
            // opcode 6 only reaches EXEC when the multiplier is not built
            default: r_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            s_q           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.ans       <= '0;
            bus.zero      <= 1'b1;
            bus.ovf       <= 1'b0;
            bus.err       <= 1'b0;
`ifdef ALU_MUL_EN
            acc           <= '0;
            mcand         <= '0;
            mcnt          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_q          <= bus.S;
                        a_q          <= bus.A;
                        b_q          <= bus.B;
                        bus.in_ready <= 1'b0;
                        state        <= EXEC;
`ifdef ALU_MUL_EN
                        if (bus.S == 3'd6) begin
                            acc   <= '0;
                            mcand <= {{W{1'b0}}, bus.A};
                            mcnt  <= CW'(W - 1);
                            state <= MUL;
                        end
`endif
                    end
                end
                EXEC: begin
                    bus.ans       <= r_ans;
                    bus.zero      <= (r_ans == '0);
                    bus.ovf       <= r_ovf;
                    bus.err       <= r_err;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    acc   <= mul_sum;
                    mcand <= mcand << 1;
                    b_q   <= b_q >> 1;
                    if (mcnt == '0) begin
                        bus.ans       <= mul_sum;
                        bus.zero      <= (mul_sum == '0);
                        bus.ovf       <= |mul_sum[2*W-1:W];
                        bus.err       <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        mcnt <= mcnt - 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed and swept checks of alu_seq at W = 8; follows ALU_MUL_EN to pick opcode 6 expectations.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    alu_seq_if #(.W(8)) bus ();

    alu_seq #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    function automatic logic [15:0] m_ans(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        case (s)
            3'd0: r = 16'(a) + 16'(b);
            3'd1: r = (16'(a) - 16'(b)) & 16'h01FF;
            3'd2: r = 16'(a & b);
            3'd3: r = 16'(a | b);
            3'd4: r = 16'(a ^ b);
            3'd5: r = 16'(a) << b[2:0];
            3'd6: r = MUL_ON ? 16'(a) * 16'(b) : 16'h0;
            default: r = 16'h0;
        endcase
        return r;
    endfunction

    function automatic logic m_ovf(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        if (s == 3'd0) return (16'(a) + 16'(b)) > 16'd255;
        if (s == 3'd1) return a < b;
        if (s == 3'd6 && MUL_ON) return (16'(a) * 16'(b)) > 16'd255;
        return 1'b0;
    endfunction

    function automatic logic m_err(input logic [2:0] s);
        return (s == 3'd7) || (s == 3'd6 && !MUL_ON);
    endfunction

    function automatic int m_lat(input logic [2:0] s);
        return (s == 3'd6 && MUL_ON) ? 9 : 2;
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen (or the budget runs out).
    task automatic run_op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b, output int lat);
        int guard;
        guard = 0;
        bus.S = s;
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        bus.S = ~s;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume(input bit rnd, input logic [15:0] exp_ans);
        logic r;
        for (int k = 0; k < 20; k++) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == 19) r = 1'b1;
            bus.out_ready = r;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            chk("hold_ans", 32'(bus.ans), 32'(exp_ans));
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                            input bit rnd);
        int lat;
        logic [15:0] ea;
        ea = m_ans(s, a, b);
        run_op(s, a, b, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(m_lat(s)));
        chk({tag, "_ans"}, 32'(bus.ans), 32'(ea));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(ea == 16'h0));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf(s, a, b)));
        chk({tag, "_err"}, 32'(bus.err), 32'(m_err(s)));
        consume(rnd, ea);
    endtask

    initial begin
        int lat;
        bit seen;
        n_chk = 0;
        n_fail = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.S = '0;
        bus.A = '0;
        bus.B = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ans", 32'(bus.ans), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 200 + 100
        run_op(3'd0, 8'd200, 8'd100, lat);
        chk("add_lat", 32'(lat), 32'd2);
        chk("add_ans", 32'(bus.ans), 32'd300);
        chk("add_ovf", 32'(bus.ovf), 32'd1);
        chk("add_zero", 32'(bus.zero), 32'd0);
        chk("add_err", 32'(bus.err), 32'd0);
        consume(1'b0, 16'd300);
        chk("idle_after_consume", 32'(bus.in_ready), 32'd1);

        // ADD all-ones boundary
        run_op(3'd0, 8'hFF, 8'hFF, lat);
        chk("add_max_ans", 32'(bus.ans), 32'h1FE);
        chk("add_max_ovf", 32'(bus.ovf), 32'd1);
        consume(1'b0, 16'h1FE);

        // SUB 5 - 5, then 0 - 1
        run_op(3'd1, 8'd5, 8'd5, lat);
        chk("sub_eq_ans", 32'(bus.ans), 32'd0);
        chk("sub_eq_zero", 32'(bus.zero), 32'd1);
        chk("sub_eq_ovf", 32'(bus.ovf), 32'd0);
        consume(1'b0, 16'd0);
        run_op(3'd1, 8'd0, 8'd1, lat);
        chk("sub_brw_ans", 32'(bus.ans), 32'h1FF);
        chk("sub_brw_ovf", 32'(bus.ovf), 32'd1);
        chk("sub_brw_zero", 32'(bus.zero), 32'd0);
        consume(1'b0, 16'h1FF);

        // MUL 255 * 255
        run_op(3'd6, 8'd255, 8'd255, lat);
        if (MUL_ON) begin
            chk("mul_lat", 32'(lat), 32'd9);
            chk("mul_ans", 32'(bus.ans), 32'd65025);
            chk("mul_ovf", 32'(bus.ovf), 32'd1);
            chk("mul_err", 32'(bus.err), 32'd0);
        end else begin
            chk("mul_lat", 32'(lat), 32'd2);
            chk("mul_ans", 32'(bus.ans), 32'd0);
            chk("mul_ovf", 32'(bus.ovf), 32'd0);
            chk("mul_err", 32'(bus.err), 32'd1);
        end
        consume(1'b0, bus.ans);

        // MUL by zero still runs the full iteration count
        run_op(3'd6, 8'd0, 8'd77, lat);
        chk("mul0_lat", 32'(lat), MUL_ON ? 32'd9 : 32'd2);
        chk("mul0_zero", 32'(bus.zero), 32'd1);
        consume(1'b0, 16'd0);

        // SHL uses only B[2:0]
        run_op(3'd5, 8'h81, 8'h0B, lat);
        chk("shl_ans", 32'(bus.ans), 32'h408);
        chk("shl_ovf", 32'(bus.ovf), 32'd0);
        consume(1'b0, 16'h408);

        // reserved opcode
        run_op(3'd7, 8'h12, 8'h34, lat);
        chk("op7_lat", 32'(lat), 32'd2);
        chk("op7_ans", 32'(bus.ans), 32'd0);
        chk("op7_err", 32'(bus.err), 32'd1);
        chk("op7_zero", 32'(bus.zero), 32'd1);
        chk("op7_ovf", 32'(bus.ovf), 32'd0);
        consume(1'b0, 16'd0);

        // back-pressure on XOR, with a competing request that must be ignored
        run_op(3'd4, 8'hF0, 8'h3C, lat);
        chk("xor_ans", 32'(bus.ans), 32'hCC);
        bus.S = 3'd0;
        bus.A = 8'd1;
        bus.B = 8'd1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_ans", 32'(bus.ans), 32'hCC);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        consume(1'b0, 16'hCC);
        chk("bp_after_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_after_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_after_ans", 32'(bus.ans), 32'hCC);

        // sweep all opcodes with random out_ready
        for (int i = 0; i < 24; i++) begin
            check_op("sweep", 3'(i), 8'(i * 37 + 3), 8'(i * 11 + 1), 1'b1);
        end

        // reset while the multiplier (or EXEC) is busy
        check_op("pre_rst", 3'd0, 8'd9, 8'd9, 1'b0);
        bus.S = 3'd6;
        bus.A = 8'd3;
        bus.B = 8'd4;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ans", 32'(bus.ans), 32'd0);
        chk("midrst_zero", 32'(bus.zero), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midrst_no_out_valid", 32'(seen), 32'd0);
        chk("midrst_idle", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 3-bit combinational ALU. It adds configurable operand width, eight opcodes, and registered results with status flags. An optional iterative multiplier is included. It sits between an operand source and a result sink, and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- W, 8: operand width in bits; legal range 2..32.
- SW, $clog2(W): width of the shift amount; derived and not overridden.

Ports:
- clk, input, 1: single clock; everything updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: an operation is offered.
- in_ready, output, 1: the block accepts an operation; high only in IDLE.
- S, input, 3: opcode.
- A, input, W: operand A, unsigned.
- B, input, W: operand B, unsigned.
- out_valid, output, 1: the result registers are valid.
- out_ready, input, 1: the sink accepts the result.
- ans, output, 2W: result.
- zero, output, 1: ans == 0.
- ovf, output, 1: carry, borrow or overflow, depending on opcode.
- err, output, 1: the opcode was illegal or disabled.

## Operation
- Handshake:
  - An operation is accepted on an edge where in_valid && in_ready.
  - S, A and B are captured into internal registers at that edge and ignored afterwards.
  - The result is consumed on an edge where out_valid && out_ready.
- FSM states are IDLE, EXEC, MUL and DONE.
  - IDLE → EXEC on accept, for any opcode other than MUL.
  - IDLE → MUL on accept of MUL when ALU_MUL_EN is defined.
  - EXEC → DONE unconditionally, writing ans, zero, ovf and err.
  - MUL → DONE after W iteration cycles.
  - DONE → IDLE on result consume.
- Opcodes (all bits of ans not listed below are 0):
  - 0 ADD: ans[W:0] = A + B; ovf = ans[W].
  - 1 SUB: ans[W:0] = {0,A} − {0,B} mod 2^(W+1); ovf = borrow (A < B).
  - 2 AND: ans[W-1:0] = A & B; ovf = 0.
  - 3 OR: ans[W-1:0] = A | B; ovf = 0.
  - 4 XOR: ans[W-1:0] = A ^ B; ovf = 0.
  - 5 SHL: ans = A << B[SW-1:0], zero-extended into 2W bits; ovf = 0. The upper bits of B are ignored.
  - 6 MUL: ans = A * B, unsigned, full 2W bits; ovf = (ans[2W-1:W] != 0).
  - 7 is reserved: ans = 0, err = 1, ovf = 0, zero = 1. The block still completes a full handshake.
- MUL is a shift-add iteration, one bit of B per cycle, LSB first. The accumulator is 2W bits wide. ans is written only on entry to DONE.
- Flag behaviour:
  - zero is computed from the final ans.
  - err = 0 for every legal opcode.
- Outputs in DONE:
  - ans and the flags hold stable while out_valid is high and out_ready is low.
  - They keep their last value after consume, until the next result overwrites them.

## Timing
- Reset values, asynchronous while rst_n = 0:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - ans = 0, zero = 1, ovf = 0, err = 0
  - the MUL accumulator and iteration counter are 0
- Reset mid-operation (EXEC, MUL or DONE) aborts immediately. The in-flight result is lost, and no out_valid pulse appears after rst_n rises.
- Latency from the accept edge to out_valid high:
  - Single-cycle opcodes and opcode 7: 2 edges (through EXEC).
  - MUL: W + 1 edges; W = 8 gives 9.
- in_ready is low from the accept edge until the consume edge.
  - Maximum throughput is one operation per 3 cycles, with out_ready held high.
- in_ready depends only on state; there is no combinational path from in_valid to in_ready.
  - out_valid is a register output.
- in_valid asserted while in_ready is low is ignored; the source must hold its values.
- If out_ready is held low, DONE persists indefinitely with all outputs stable.
- Widths and boundary behaviour:
  - ADD: all-ones + all-ones gives ovf = 1 and ans = 2^(W+1) − 2.
  - SUB: 0 − 1 gives ans[W:0] all-ones and ovf = 1.
  - MUL: an operand of 0 still takes the full W cycles.

## Configuration
- Macro: ALU_MUL_EN.
- When defined, the MUL state and the shift-add datapath are compiled in, and opcode 6 behaves as specified above.
- When undefined, the MUL state and the multiplier logic are absent. Opcode 6 is then handled exactly like opcode 7: ans = 0, err = 1, ovf = 0, zero = 1, with a 2-edge latency through EXEC.

## Test plan
All scenarios use W = 8.
- Reset, then ADD A = 200, B = 100, out_ready = 1 → out_valid 2 edges after accept; ans = 300, ovf = 1, zero = 0, err = 0.
- SUB A = 5, B = 5, then SUB A = 0, B = 1 → first: ans = 0, zero = 1, ovf = 0. Second: ans[8:0] = 0x1FF, ovf = 1.
- MUL A = 255, B = 255 with ALU_MUL_EN defined → out_valid 9 edges after accept; ans = 65025, ovf = 1. Without the macro: ans = 0, err = 1, after 2 edges.
- SHL A = 0x81, B = 0x0B → shift amount is 3; ans = 0x408. Opcode 7 → ans = 0, err = 1, zero = 1.
- Back-pressure: out_ready = 0 for 5 cycles after an XOR A = 0xF0, B = 0x3C → ans = 0xCC stays stable and in_ready = 0 throughout. A new in_valid during this time is not accepted.
- Sweep and reset:
  - Sweep all 8 opcodes with A and B incrementing and random out_ready; compare every output against a reference model.
  - Pull rst_n low during the MUL state → outputs return to reset values at once, and no out_valid follows.
